// File: rtl/graph_mem_pkg.sv
// Shared types and defaults for the graph memory responder: FSM state encoding,
// bus width defaults and the byte-address to word-index shift.
package graph_mem_pkg;

    localparam int DEFAULT_MADDR_WIDTH = 16;
    localparam int DEFAULT_MDATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } resp_state_e;

    function automatic int unsigned byte_to_word_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/graph_mem_array.sv
// Word storage: synchronous front-door and backdoor write ports, asynchronous read.
// Contents are deliberately not reset.
module graph_mem_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          fd_we_i,
    input  logic [IW-1:0] fd_idx_i,
    input  logic [DW-1:0] fd_data_i,
    input  logic          bd_we_i,
    input  logic [IW-1:0] bd_idx_i,
    input  logic [DW-1:0] bd_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [DW-1:0] rd_data_o
);

    localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic bd_in_range;
    logic rd_in_range;
    assign bd_in_range = {1'b0, bd_idx_i} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_idx_i} < DEPTH_L;

    // Front-door write is last so it wins a same-word collision with a backdoor load.
    always_ff @(posedge clock) begin
        if (bd_we_i && bd_in_range) mem_q[bd_idx_i] <= bd_data_i;
        if (fd_we_i)                mem_q[fd_idx_i] <= fd_data_i;
    end

    assign rd_data_o = rd_in_range ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/graph_memory_responder.sv
// Memory-side end of the solver's mem_* handshake: latency-configurable
// read/write responder with backdoor preload and sticky out-of-range flag.
module graph_memory_responder
    import graph_mem_pkg::*;
#(
    parameter int MADDR_WIDTH   = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH   = DEFAULT_MDATA_WIDTH,
    parameter int DEPTH_WORDS   = 256,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mem_read_enable,
    input  logic                           mem_write_enable,
    input  logic [MADDR_WIDTH-1:0]         mem_addr,
    input  logic [MDATA_WIDTH-1:0]         mem_write_data,
    output logic [MDATA_WIDTH-1:0]         mem_read_data,
    output logic                           mem_read_ready,
    output logic                           mem_write_ready,
    input  logic                           load_enable,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_word_index,
    input  logic [MDATA_WIDTH-1:0]         load_data,
    output logic                           addr_error
);

    localparam int SHIFT = byte_to_word_shift(MDATA_WIDTH);
    localparam int IW    = $clog2(DEPTH_WORDS);
    localparam int MAXL  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW    = $clog2(MAXL + 1);
    localparam logic [MADDR_WIDTH:0] DEPTH_A = (MADDR_WIDTH + 1)'(DEPTH_WORDS);

    resp_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   rrdy_q, rrdy_d;
    logic                   wrdy_q, wrdy_d;
    logic                   err_q, err_d;
    logic                   served_wr_q, served_wr_d;

    logic [MADDR_WIDTH-1:0] cur_addr;
    logic [MDATA_WIDTH-1:0] cur_wdata;
    logic [MADDR_WIDTH-1:0] word;
    logic                   in_range;
    logic [MDATA_WIDTH-1:0] arr_rdata;
    logic                   ack_rd, ack_wr, fd_we;

    // In IDLE a latency-1 transaction completes on its accept edge, so use the live bus.
    assign cur_addr  = (state_q == IDLE) ? mem_addr : addr_q;
    assign cur_wdata = (state_q == IDLE) ? mem_write_data : wdata_q;
    assign word      = cur_addr >> SHIFT;
    assign in_range  = {1'b0, word} < DEPTH_A;

    graph_mem_array #(
        .DW    (MDATA_WIDTH),
        .DEPTH (DEPTH_WORDS),
        .IW    (IW)
    ) u_array (
        .clock     (clock),
        .fd_we_i   (fd_we),
        .fd_idx_i  (word[IW-1:0]),
        .fd_data_i (cur_wdata),
        .bd_we_i   (load_enable),
        .bd_idx_i  (load_word_index),
        .bd_data_i (load_data),
        .rd_idx_i  (word[IW-1:0]),
        .rd_data_o (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        served_wr_d = served_wr_q;
        rrdy_d      = 1'b0;
        wrdy_d      = 1'b0;
        ack_rd      = 1'b0;
        ack_wr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_write_enable) begin
                    addr_d      = mem_addr;
                    wdata_d     = mem_write_data;
                    served_wr_d = 1'b1;
                    if (WRITE_LATENCY == 1) ack_wr = 1'b1;
                    else begin
                        cnt_d   = CW'(WRITE_LATENCY - 1);
                        state_d = WRITE_WAIT;
                    end
                end else if (mem_read_enable) begin
                    addr_d      = mem_addr;
                    served_wr_d = 1'b0;
                    if (READ_LATENCY == 1) ack_rd = 1'b1;
                    else begin
                        cnt_d   = CW'(READ_LATENCY - 1);
                        state_d = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (!mem_read_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) ack_rd = 1'b1;
                else cnt_d = cnt_q - CW'(1);
            end
            WRITE_WAIT: begin
                if (!mem_write_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) ack_wr = 1'b1;
                else cnt_d = cnt_q - CW'(1);
            end
            RELEASE: begin
                if (served_wr_q ? !mem_write_enable : !mem_read_enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (ack_rd) begin
            rrdy_d  = 1'b1;
            rdata_d = in_range ? arr_rdata : '0;
            err_d   = err_q | ~in_range;
            cnt_d   = '0;
            state_d = RELEASE;
        end
        if (ack_wr) begin
            wrdy_d  = 1'b1;
            err_d   = err_q | ~in_range;
            cnt_d   = '0;
            state_d = RELEASE;
        end
    end

    // The storage has no reset, so a commit coinciding with reset must be gated here.
    assign fd_we = ack_wr & in_range & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rrdy_q      <= 1'b0;
            wrdy_q      <= 1'b0;
            err_q       <= 1'b0;
            served_wr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rrdy_q      <= rrdy_d;
            wrdy_q      <= wrdy_d;
            err_q       <= err_d;
            served_wr_q <= served_wr_d;
        end
    end

    assign mem_read_data   = rdata_q;
    assign mem_read_ready  = rrdy_q;
    assign mem_write_ready = wrdy_q;
    assign addr_error      = err_q;

endmodule

// File: tb/tb_graph_memory_responder.sv
// Directed bench: one responder with default latencies (scoreboarded reads) and
// one with READ_LATENCY=4 / WRITE_LATENCY=3 for abandon and mid-wait reset cases.
module tb_graph_memory_responder;
    import graph_mem_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int IW    = $clog2(DEPTH);
    localparam int BPW   = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          re, we, re4, we4;
    logic [AW-1:0] addr, addr4;
    logic [DW-1:0] wd, wd4;
    logic [DW-1:0] rd, rd4;
    logic          rr, wr, err, rr4, wr4, err4;
    logic          ld_en;
    logic [IW-1:0] ld_idx;
    logic [DW-1:0] ld_data;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] sb_exp;
    int            pulses;

    always #5 clk = ~clk;

    graph_memory_responder #(
        .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
        .READ_LATENCY(2), .WRITE_LATENCY(1)
    ) dut (
        .clock(clk), .reset(rst),
        .mem_read_enable(re), .mem_write_enable(we),
        .mem_addr(addr), .mem_write_data(wd),
        .mem_read_data(rd), .mem_read_ready(rr), .mem_write_ready(wr),
        .load_enable(ld_en), .load_word_index(ld_idx), .load_data(ld_data),
        .addr_error(err)
    );

    graph_memory_responder #(
        .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
        .READ_LATENCY(4), .WRITE_LATENCY(3)
    ) dut4 (
        .clock(clk), .reset(rst),
        .mem_read_enable(re4), .mem_write_enable(we4),
        .mem_addr(addr4), .mem_write_data(wd4),
        .mem_read_data(rd4), .mem_read_ready(rr4), .mem_write_ready(wr4),
        .load_enable(ld_en), .load_word_index(ld_idx), .load_data(ld_data),
        .addr_error(err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every read acknowledge of the default-latency responder pops one expectation.
    always @(negedge clk) begin
        if (!rst && rr) begin
            chk("sb_ack_expected", 64'(sb_q.size() > 0), 64'(1));
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                chk("sb_read_data", 64'(rd), 64'(sb_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; re = 0; we = 0; re4 = 0; we4 = 0;
        addr = '0; addr4 = '0; wd = '0; wd4 = '0;
        ld_en = 0; ld_idx = '0; ld_data = '0;
        step(3);
        chk("rst_rr", 64'(rr), 0);
        chk("rst_wr", 64'(wr), 0);
        chk("rst_rd", 64'(rd), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        rst = 1'b0;

        // backdoor preload words 0..3 (both responders share the load bus)
        for (int i = 0; i < 4; i++) begin
            ld_en = 1; ld_idx = IW'(i); ld_data = DW'((i + 1) * 10);
            step(1);
        end
        ld_en = 0;
        step(1);

        // read word 2: ready exactly two cycles after the request is sampled
        addr = AW'(2 * BPW); re = 1; sb_q.push_back(30);
        step(1);
        chk("rd_lat_early", 64'(rr), 0);
        step(1);
        chk("rd_lat_ack", 64'(rr), 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            pulses += int'(rr);
        end
        chk("held_read_single_pulse", 64'(pulses), 0);
        re = 0;
        step(1);
        re = 1; sb_q.push_back(30);
        step(1);
        chk("reassert_early", 64'(rr), 0);
        step(1);
        chk("reassert_ack", 64'(rr), 1);
        re = 0;
        step(2);

        // simultaneous read+write: write wins
        addr = AW'(5 * BPW); wd = 32'hAB; we = 1; re = 1;
        step(1);
        chk("rw_write_ack", 64'(wr), 1);
        chk("rw_no_read_ack", 64'(rr), 0);
        we = 0; re = 0;
        step(1);
        chk("rw_write_single", 64'(wr), 0);
        chk("rw_read_none", 64'(rr), 0);
        re = 1; sb_q.push_back(32'hAB);
        step(2);
        chk("readback_ack", 64'(rr), 1);
        re = 0;
        step(2);

        // out-of-range read
        addr = AW'((DEPTH + 1) * BPW); re = 1; sb_q.push_back(0);
        step(2);
        chk("oor_ack", 64'(rr), 1);
        chk("oor_err", 64'(err), 1);
        re = 0;
        step(2);
        addr = AW'(0); re = 1; sb_q.push_back(10);
        step(2);
        chk("valid_after_oor_ack", 64'(rr), 1);
        chk("err_sticky", 64'(err), 1);
        re = 0;
        step(2);

        // READ_LATENCY=4: abandon one cycle after acceptance
        addr4 = AW'(2 * BPW); re4 = 1;
        step(1);
        re4 = 0;
        step(1);
        chk("abandon_idle", 64'(dut4.state_q), 64'(IDLE));
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            pulses += int'(rr4);
        end
        chk("abandon_no_ack", 64'(pulses), 0);
        addr4 = AW'(3 * BPW); re4 = 1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("lat4_ready", 64'(rr4), 64'(k == 4));
        end
        chk("lat4_data", 64'(rd4), 40);
        re4 = 0;
        step(2);

        // reset during WRITE_WAIT aborts the write to word 1
        addr4 = AW'(1 * BPW); wd4 = 32'h55; we4 = 1;
        step(1);
        chk("ww_state", 64'(dut4.state_q), 64'(WRITE_WAIT));
        step(1);
        chk("ww_no_ack_yet", 64'(wr4), 0);
        rst = 1;
        step(1);
        rst = 0; we4 = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            pulses += int'(wr4);
        end
        chk("rst_abort_no_ack", 64'(pulses), 0);
        chk("rst_clears_err", 64'(err), 0);
        addr4 = AW'(1 * BPW); re4 = 1;
        step(4);
        chk("rst_word_unchanged_ack", 64'(rr4), 1);
        chk("rst_word_unchanged", 64'(rd4), 20);
        re4 = 0;
        step(2);
        addr = AW'(3 * BPW); re = 1; sb_q.push_back(40);
        step(2);
        chk("retained_after_rst_ack", 64'(rr), 1);
        re = 0;
        step(3);

        chk("sb_drained", 64'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
